// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_pkg
// Purpose  : Shared encodings for the I/D cache main-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    localparam int unsigned c_BUS_W = 32;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_GRANT  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic c_PORT_I = 1'b0;
    localparam logic c_PORT_D = 1'b1;

    function automatic logic port_req(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Combinational two-way winner select (round-robin or D priority).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_bus_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_last_winner,
    output logic o_winner
);

    always_comb begin
        o_winner = c_PORT_I;
        if (i_req_i && i_req_d)
            o_winner = RR_EN ? ~i_last_winner : c_PORT_D;
        else if (i_req_d)
            o_winner = c_PORT_D;
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one SRAM-controller port between the I-cache and D-cache.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter bit                 RR_EN    = 1'b1,
    parameter int unsigned        TIMEOUT  = 255,
    parameter logic [c_BUS_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_read_mem,
    input  logic               i_write_mem,
    output logic               i_grant_mem,
    output logic               i_ready_mem,
    input  logic [c_BUS_W-1:0] i_adbus,
    input  logic [c_BUS_W-1:0] i_wdata,
    output logic [c_BUS_W-1:0] i_rdata,
    input  logic               d_read_mem,
    input  logic               d_write_mem,
    output logic               d_grant_mem,
    output logic               d_ready_mem,
    input  logic [c_BUS_W-1:0] d_adbus,
    input  logic [c_BUS_W-1:0] d_wdata,
    output logic [c_BUS_W-1:0] d_rdata,
    output logic               m_read,
    output logic               m_write,
    output logic [c_BUS_W-1:0] m_addr,
    output logic [c_BUS_W-1:0] m_wdata,
    input  logic [c_BUS_W-1:0] m_rdata,
    input  logic               m_ready,
    output logic               busy,
    output logic               timeout_err
);

    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]         r_state, w_state_nxt;
    logic               r_winner, w_winner_nxt;
    logic               r_last_winner, w_last_winner_nxt;
    logic               r_is_write, w_is_write_nxt;
    logic [7:0]         r_cnt, w_cnt_nxt;
    logic               r_i_grant, w_i_grant_nxt;
    logic               r_d_grant, w_d_grant_nxt;
    logic               r_i_ready, w_i_ready_nxt;
    logic               r_d_ready, w_d_ready_nxt;
    logic [c_BUS_W-1:0] r_i_rdata, w_i_rdata_nxt;
    logic [c_BUS_W-1:0] r_d_rdata, w_d_rdata_nxt;
    logic               r_m_read, w_m_read_nxt;
    logic               r_m_write, w_m_write_nxt;
    logic [c_BUS_W-1:0] r_m_addr, w_m_addr_nxt;
    logic [c_BUS_W-1:0] r_m_wdata, w_m_wdata_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_timeout_err, w_timeout_err_nxt;

    logic               w_req_i, w_req_d, w_arb_winner;
    logic               w_win_req, w_win_wr, w_timeout;
    logic [c_BUS_W-1:0] w_win_addr, w_win_wdata;

    assign w_req_i     = port_req(i_read_mem, i_write_mem);
    assign w_req_d     = port_req(d_read_mem, d_write_mem);
    assign w_win_req   = (r_winner == c_PORT_D) ? w_req_d     : w_req_i;
    // Write takes precedence when a cache raises both strobes.
    assign w_win_wr    = (r_winner == c_PORT_D) ? d_write_mem : i_write_mem;
    assign w_win_addr  = (r_winner == c_PORT_D) ? d_adbus     : i_adbus;
    assign w_win_wdata = (r_winner == c_PORT_D) ? d_wdata     : i_wdata;
    assign w_timeout   = (r_cnt == c_TO_LAST);

    rr_arbiter2 #(
        .RR_EN(RR_EN)
    ) u_rr_arbiter2 (
        .i_req_i      (w_req_i),
        .i_req_d      (w_req_d),
        .i_last_winner(r_last_winner),
        .o_winner     (w_arb_winner)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_winner      <= c_PORT_I;
            r_last_winner <= c_PORT_I;
            r_is_write    <= 1'b0;
            r_cnt         <= '0;
            r_i_grant     <= 1'b0;
            r_d_grant     <= 1'b0;
            r_i_ready     <= 1'b0;
            r_d_ready     <= 1'b0;
            r_i_rdata     <= '0;
            r_d_rdata     <= '0;
            r_m_read      <= 1'b0;
            r_m_write     <= 1'b0;
            r_m_addr      <= '0;
            r_m_wdata     <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_winner      <= w_winner_nxt;
            r_last_winner <= w_last_winner_nxt;
            r_is_write    <= w_is_write_nxt;
            r_cnt         <= w_cnt_nxt;
            r_i_grant     <= w_i_grant_nxt;
            r_d_grant     <= w_d_grant_nxt;
            r_i_ready     <= w_i_ready_nxt;
            r_d_ready     <= w_d_ready_nxt;
            r_i_rdata     <= w_i_rdata_nxt;
            r_d_rdata     <= w_d_rdata_nxt;
            r_m_read      <= w_m_read_nxt;
            r_m_write     <= w_m_write_nxt;
            r_m_addr      <= w_m_addr_nxt;
            r_m_wdata     <= w_m_wdata_nxt;
            r_busy        <= w_busy_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_req_i || w_req_d)     w_state_nxt = c_GRANT;
            c_GRANT:  w_state_nxt = w_win_req ? c_ACCESS : c_IDLE;
            c_ACCESS: if (m_ready || w_timeout)   w_state_nxt = c_DONE;
            c_DONE:   if (!w_win_req)             w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_winner_nxt      = r_winner;
        w_last_winner_nxt = r_last_winner;
        w_is_write_nxt    = r_is_write;
        w_cnt_nxt         = r_cnt;
        w_i_grant_nxt     = r_i_grant;
        w_d_grant_nxt     = r_d_grant;
        w_i_ready_nxt     = r_i_ready;
        w_d_ready_nxt     = r_d_ready;
        w_i_rdata_nxt     = r_i_rdata;
        w_d_rdata_nxt     = r_d_rdata;
        w_m_read_nxt      = r_m_read;
        w_m_write_nxt     = r_m_write;
        w_m_addr_nxt      = r_m_addr;
        w_m_wdata_nxt     = r_m_wdata;
        w_timeout_err_nxt = r_timeout_err;
        w_busy_nxt        = (w_state_nxt != c_IDLE);
        case (r_state)
            c_IDLE: begin
                if (w_req_i || w_req_d) begin
                    w_winner_nxt  = w_arb_winner;
                    w_i_grant_nxt = (w_arb_winner == c_PORT_I);
                    w_d_grant_nxt = (w_arb_winner == c_PORT_D);
                end
            end
            c_GRANT: begin
                if (w_win_req) begin
                    w_m_addr_nxt   = w_win_addr;
                    w_m_wdata_nxt  = w_win_wdata;
                    w_is_write_nxt = w_win_wr;
                    w_m_read_nxt   = ~w_win_wr;
                    w_m_write_nxt  = w_win_wr;
                    w_cnt_nxt      = '0;
                end else begin
                    // Aborted grant: no memory access, arbitration history untouched.
                    w_i_grant_nxt = 1'b0;
                    w_d_grant_nxt = 1'b0;
                end
            end
            c_ACCESS: begin
                if (m_ready || w_timeout) begin
                    w_m_read_nxt      = 1'b0;
                    w_m_write_nxt     = 1'b0;
                    w_last_winner_nxt = r_winner;
                    if (r_winner == c_PORT_D) begin
                        w_d_ready_nxt = 1'b1;
                        if (!r_is_write) w_d_rdata_nxt = m_ready ? m_rdata : ERR_DATA;
                    end else begin
                        w_i_ready_nxt = 1'b1;
                        if (!r_is_write) w_i_rdata_nxt = m_ready ? m_rdata : ERR_DATA;
                    end
                    if (!m_ready) w_timeout_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            c_DONE: begin
                if (!w_win_req) begin
                    w_i_grant_nxt = 1'b0;
                    w_d_grant_nxt = 1'b0;
                    w_i_ready_nxt = 1'b0;
                    w_d_ready_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign i_grant_mem = r_i_grant;
    assign d_grant_mem = r_d_grant;
    assign i_ready_mem = r_i_ready;
    assign d_ready_mem = r_d_ready;
    assign i_rdata     = r_i_rdata;
    assign d_rdata     = r_d_rdata;
    assign m_read      = r_m_read;
    assign m_write     = r_m_write;
    assign m_addr      = r_m_addr;
    assign m_wdata     = r_m_wdata;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed self-checking bench for mem_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_read_mem, i_write_mem, i_grant_mem, i_ready_mem;
    logic [31:0] i_adbus, i_wdata, i_rdata;
    logic        d_read_mem, d_write_mem, d_grant_mem, d_ready_mem;
    logic [31:0] d_adbus, d_wdata, d_rdata;
    logic        m_read, m_write, m_ready, busy, timeout_err;
    logic [31:0] m_addr, m_wdata, m_rdata;

    logic        f_i_read, f_d_read, f_m_ready;
    logic [31:0] f_m_rdata;
    logic        f_i_grant, f_i_ready, f_d_grant, f_d_ready;
    logic        f_m_read, f_m_write, f_busy, f_terr;
    logic [31:0] f_i_rdata, f_d_rdata, f_m_addr, f_m_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.RR_EN(1'b1), .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read_mem(i_read_mem), .i_write_mem(i_write_mem), .i_grant_mem(i_grant_mem),
        .i_ready_mem(i_ready_mem), .i_adbus(i_adbus), .i_wdata(i_wdata), .i_rdata(i_rdata),
        .d_read_mem(d_read_mem), .d_write_mem(d_write_mem), .d_grant_mem(d_grant_mem),
        .d_ready_mem(d_ready_mem), .d_adbus(d_adbus), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy), .timeout_err(timeout_err)
    );

    mem_bus_arbiter #(.RR_EN(1'b0), .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .i_read_mem(f_i_read), .i_write_mem(1'b0), .i_grant_mem(f_i_grant),
        .i_ready_mem(f_i_ready), .i_adbus(32'h0000_0A00), .i_wdata(32'h0), .i_rdata(f_i_rdata),
        .d_read_mem(f_d_read), .d_write_mem(1'b0), .d_grant_mem(f_d_grant),
        .d_ready_mem(f_d_ready), .d_adbus(32'h0000_0B00), .d_wdata(32'h0), .d_rdata(f_d_rdata),
        .m_read(f_m_read), .m_write(f_m_write), .m_addr(f_m_addr), .m_wdata(f_m_wdata),
        .m_rdata(f_m_rdata), .m_ready(f_m_ready), .busy(f_busy), .timeout_err(f_terr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        i_read_mem = 0; i_write_mem = 0; i_adbus = 0; i_wdata = 0;
        d_read_mem = 0; d_write_mem = 0; d_adbus = 0; d_wdata = 0;
        m_ready = 0; m_rdata = 0;
        f_i_read = 0; f_d_read = 0; f_m_ready = 0; f_m_rdata = 0;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        do_reset;
        n_tests++; if ({i_grant_mem, d_grant_mem, i_ready_mem, d_ready_mem, m_read, m_write, busy, timeout_err} !== 8'h00) begin n_fail++; $display("FAIL rst_ctrl got=%b exp=00000000", {i_grant_mem, d_grant_mem, i_ready_mem, d_ready_mem, m_read, m_write, busy, timeout_err}); end
        n_tests++; if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'h0) begin n_fail++; $display("FAIL rst_data got=%h exp=0", {m_addr, m_wdata, i_rdata, d_rdata}); end
        m_ready = 1'b1; m_rdata = 32'hFFFF_FFFF;
        tick;
        m_ready = 1'b0;
        tick;
        n_tests++; if ({i_ready_mem, d_ready_mem, busy, i_rdata} !== 35'h0) begin n_fail++; $display("FAIL idle_mready got=%h exp=0", {i_ready_mem, d_ready_mem, busy, i_rdata}); end
    endtask

    task automatic test_i_read;
        i_read_mem = 1'b1; i_adbus = 32'h0000_0040;
        tick;
        n_tests++; if ({i_grant_mem, d_grant_mem, m_read, busy} !== 4'b1001) begin n_fail++; $display("FAIL rd_grant got=%b exp=1001", {i_grant_mem, d_grant_mem, m_read, busy}); end
        tick;
        n_tests++; if ({m_read, m_write} !== 2'b10 || m_addr !== 32'h40) begin n_fail++; $display("FAIL rd_strobe got=%b/%h exp=10/00000040", {m_read, m_write}, m_addr); end
        tick; tick;
        n_tests++; if ({i_ready_mem, m_read} !== 2'b01) begin n_fail++; $display("FAIL rd_wait got=%b exp=01", {i_ready_mem, m_read}); end
        m_ready = 1'b1; m_rdata = 32'h1234_5678;
        tick;
        m_ready = 1'b0;
        n_tests++; if ({i_grant_mem, i_ready_mem, m_read} !== 3'b110 || i_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_done got=%b/%h exp=110/12345678", {i_grant_mem, i_ready_mem, m_read}, i_rdata); end
        tick;
        n_tests++; if ({i_grant_mem, i_ready_mem} !== 2'b11 || i_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_hold got=%b/%h exp=11/12345678", {i_grant_mem, i_ready_mem}, i_rdata); end
        i_read_mem = 1'b0;
        tick;
        n_tests++; if ({i_grant_mem, i_ready_mem, busy} !== 3'b000 || i_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_release got=%b/%h exp=000/12345678", {i_grant_mem, i_ready_mem, busy}, i_rdata); end
    endtask

    task automatic test_d_write;
        d_write_mem = 1'b1; d_adbus = 32'h0000_0100; d_wdata = 32'hCAFE_F00D;
        tick;
        n_tests++; if ({i_grant_mem, d_grant_mem} !== 2'b01) begin n_fail++; $display("FAIL wr_grant got=%b exp=01", {i_grant_mem, d_grant_mem}); end
        tick;
        n_tests++; if ({m_read, m_write} !== 2'b01 || m_addr !== 32'h100 || m_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wr_strobe got=%b/%h/%h exp=01/00000100/cafef00d", {m_read, m_write}, m_addr, m_wdata); end
        m_ready = 1'b1; m_rdata = 32'h5555_5555;
        tick;
        m_ready = 1'b0;
        n_tests++; if ({d_ready_mem, m_write, i_grant_mem, i_ready_mem} !== 4'b1000) begin n_fail++; $display("FAIL wr_done got=%b exp=1000", {d_ready_mem, m_write, i_grant_mem, i_ready_mem}); end
        n_tests++; if (d_rdata !== 32'h0 || i_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_rdata got=%h/%h exp=00000000/12345678", d_rdata, i_rdata); end
        d_write_mem = 1'b0;
        tick;
        n_tests++; if ({d_grant_mem, d_ready_mem, busy} !== 3'b000) begin n_fail++; $display("FAIL wr_release got=%b exp=000", {d_grant_mem, d_ready_mem, busy}); end
    endtask

    task automatic test_round_robin;
        logic [1:0] reqs [0:5];
        logic [5:0] exp_d;
        logic       w;
        reqs = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11};
        exp_d = 6'b100101;
        do_reset;
        i_adbus = 32'h200; d_adbus = 32'h300;
        // Both request; D wins, I stays pending and follows after one idle cycle.
        i_read_mem = 1'b1; d_read_mem = 1'b1;
        tick;
        n_tests++; if ({i_grant_mem, d_grant_mem} !== 2'b01) begin n_fail++; $display("FAIL rr_first got=%b exp=01", {i_grant_mem, d_grant_mem}); end
        tick;
        m_ready = 1'b1; m_rdata = 32'hD0D0_0001;
        tick;
        m_ready = 1'b0; d_read_mem = 1'b0;
        tick;
        n_tests++; if ({i_grant_mem, d_grant_mem, busy} !== 3'b000) begin n_fail++; $display("FAIL rr_gap got=%b exp=000", {i_grant_mem, d_grant_mem, busy}); end
        tick;
        n_tests++; if ({i_grant_mem, d_grant_mem} !== 2'b10) begin n_fail++; $display("FAIL rr_pending got=%b exp=10", {i_grant_mem, d_grant_mem}); end
        tick;
        m_ready = 1'b1; m_rdata = 32'h1111_0002;
        tick;
        m_ready = 1'b0; i_read_mem = 1'b0;
        tick;
        for (int k = 0; k < 6; k++) begin
            w = exp_d[k];
            i_read_mem = reqs[k][1]; d_read_mem = reqs[k][0];
            tick;
            n_tests++; if ({i_grant_mem, d_grant_mem} !== (w ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, {i_grant_mem, d_grant_mem}, (w ? 2'b01 : 2'b10)); end
            tick;
            n_tests++; if (m_read !== 1'b1 || m_addr !== (w ? 32'h300 : 32'h200)) begin n_fail++; $display("FAIL rr_addr[%0d] got=%b/%h exp=1/%h", k, m_read, m_addr, (w ? 32'h300 : 32'h200)); end
            m_ready = 1'b1; m_rdata = 32'hA000_0000 + 32'(k);
            tick;
            m_ready = 1'b0;
            n_tests++; if ({i_ready_mem, d_ready_mem} !== (w ? 2'b01 : 2'b10) || (w ? d_rdata : i_rdata) !== 32'hA000_0000 + 32'(k)) begin n_fail++; $display("FAIL rr_done[%0d] got=%b/%h exp=%b/%h", k, {i_ready_mem, d_ready_mem}, (w ? d_rdata : i_rdata), (w ? 2'b01 : 2'b10), 32'hA000_0000 + 32'(k)); end
            i_read_mem = 1'b0; d_read_mem = 1'b0;
            tick;
        end
    endtask

    task automatic test_fixed_prio;
        logic [1:0] reqs [0:3];
        logic [3:0] exp_d;
        logic       w;
        reqs = '{2'b11, 2'b11, 2'b10, 2'b11};
        exp_d = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            w = exp_d[k];
            f_i_read = reqs[k][1]; f_d_read = reqs[k][0];
            tick;
            n_tests++; if ({f_i_grant, f_d_grant} !== (w ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL fp_grant[%0d] got=%b exp=%b", k, {f_i_grant, f_d_grant}, (w ? 2'b01 : 2'b10)); end
            tick;
            n_tests++; if ({f_m_read, f_m_write} !== 2'b10 || f_m_addr !== (w ? 32'hB00 : 32'hA00)) begin n_fail++; $display("FAIL fp_addr[%0d] got=%b/%h exp=10/%h", k, {f_m_read, f_m_write}, f_m_addr, (w ? 32'hB00 : 32'hA00)); end
            f_m_ready = 1'b1; f_m_rdata = 32'hF000_0000 + 32'(k);
            tick;
            f_m_ready = 1'b0;
            n_tests++; if ({f_i_ready, f_d_ready} !== (w ? 2'b01 : 2'b10) || (w ? f_d_rdata : f_i_rdata) !== 32'hF000_0000 + 32'(k)) begin n_fail++; $display("FAIL fp_done[%0d] got=%b/%h", k, {f_i_ready, f_d_ready}, (w ? f_d_rdata : f_i_rdata)); end
            f_i_read = 1'b0; f_d_read = 1'b0;
            tick;
        end
        n_tests++; if ({f_busy, f_terr} !== 2'b00 || f_m_wdata !== 32'h0) begin n_fail++; $display("FAIL fp_idle got=%b/%h exp=00/0", {f_busy, f_terr}, f_m_wdata); end
    endtask

    task automatic test_timeout_edge;
        d_read_mem = 1'b1; d_adbus = 32'h600;
        tick; tick;
        repeat (7) tick;
        n_tests++; if ({d_ready_mem, m_read} !== 2'b01) begin n_fail++; $display("FAIL toedge_wait got=%b exp=01", {d_ready_mem, m_read}); end
        m_ready = 1'b1; m_rdata = 32'h7777_0001;
        tick;
        m_ready = 1'b0;
        n_tests++; if ({d_ready_mem, timeout_err} !== 2'b10 || d_rdata !== 32'h7777_0001) begin n_fail++; $display("FAIL toedge_done got=%b/%h exp=10/77770001", {d_ready_mem, timeout_err}, d_rdata); end
        d_read_mem = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        d_read_mem = 1'b1; d_adbus = 32'h700;
        tick; tick;
        repeat (7) tick;
        n_tests++; if ({d_ready_mem, m_read, timeout_err} !== 3'b010) begin n_fail++; $display("FAIL to_wait got=%b exp=010", {d_ready_mem, m_read, timeout_err}); end
        tick;
        n_tests++; if ({d_ready_mem, m_read, timeout_err} !== 3'b101 || d_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_done got=%b/%h exp=101/deadbeef", {d_ready_mem, m_read, timeout_err}, d_rdata); end
        d_read_mem = 1'b0;
        tick; tick;
        n_tests++; if ({d_grant_mem, busy, timeout_err} !== 3'b001) begin n_fail++; $display("FAIL to_sticky got=%b exp=001", {d_grant_mem, busy, timeout_err}); end
    endtask

    task automatic test_reset_mid;
        i_read_mem = 1'b1; i_adbus = 32'h80;
        tick; tick;
        n_tests++; if (m_read !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got=%b exp=1", m_read); end
        rst_n = 1'b0; i_read_mem = 1'b0;
        tick;
        n_tests++; if ({m_read, i_grant_mem, i_ready_mem, busy, timeout_err} !== 5'b0) begin n_fail++; $display("FAIL rmid_clear got=%b exp=00000", {m_read, i_grant_mem, i_ready_mem, busy, timeout_err}); end
        rst_n = 1'b1;
        tick;
        d_write_mem = 1'b1; d_adbus = 32'h900; d_wdata = 32'h1357_9BDF;
        tick; tick;
        n_tests++; if ({m_read, m_write} !== 2'b01 || m_addr !== 32'h900 || m_wdata !== 32'h1357_9BDF) begin n_fail++; $display("FAIL rmid_fresh got=%b/%h/%h", {m_read, m_write}, m_addr, m_wdata); end
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0; d_write_mem = 1'b0;
        n_tests++; if (d_ready_mem !== 1'b1) begin n_fail++; $display("FAIL rmid_done got=%b exp=1", d_ready_mem); end
        tick;
    endtask

    task automatic test_abort;
        do_reset;
        i_read_mem = 1'b1; d_read_mem = 1'b1; i_adbus = 32'hC0; d_adbus = 32'hD0;
        tick;
        n_tests++; if ({i_grant_mem, d_grant_mem} !== 2'b01) begin n_fail++; $display("FAIL ab_grant got=%b exp=01", {i_grant_mem, d_grant_mem}); end
        d_read_mem = 1'b0;
        tick;
        n_tests++; if ({i_grant_mem, d_grant_mem, m_read, m_write, busy} !== 5'b0) begin n_fail++; $display("FAIL ab_idle got=%b exp=00000", {i_grant_mem, d_grant_mem, m_read, m_write, busy}); end
        tick;
        n_tests++; if ({i_grant_mem, d_grant_mem, m_read} !== 3'b100) begin n_fail++; $display("FAIL ab_next got=%b exp=100", {i_grant_mem, d_grant_mem, m_read}); end
        tick;
        n_tests++; if (m_read !== 1'b1 || m_addr !== 32'hC0) begin n_fail++; $display("FAIL ab_strobe got=%b/%h exp=1/000000c0", m_read, m_addr); end
        m_ready = 1'b1; m_rdata = 32'h4242_4242;
        tick;
        m_ready = 1'b0; i_read_mem = 1'b0;
        n_tests++; if (i_ready_mem !== 1'b1 || i_rdata !== 32'h4242_4242) begin n_fail++; $display("FAIL ab_done got=%b/%h exp=1/42424242", i_ready_mem, i_rdata); end
        tick;
    endtask

    task automatic test_both_rw;
        i_read_mem = 1'b1; i_write_mem = 1'b1; i_adbus = 32'hE0; i_wdata = 32'h0BAD_F00D;
        tick; tick;
        n_tests++; if ({m_read, m_write} !== 2'b01 || m_wdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rw_wins got=%b/%h exp=01/0badf00d", {m_read, m_write}, m_wdata); end
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0; i_read_mem = 1'b0; i_write_mem = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_i_read;
        test_d_write;
        test_round_robin;
        test_fixed_prio;
        test_timeout_edge;
        test_timeout;
        test_reset_mid;
        test_abort;
        test_both_rw;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-port arbiter sharing one main-memory port between the instruction cache (port I) and the data cache (port D).
- Each cache-side port uses the cache's memory handshake: read_mem/write_mem request, grant_mem, ready_mem.
- The memory side is a simple registered request/ready interface to the SRAM controller.
- One transaction is in flight at a time; the block sequences grant, address/data capture, memory access and completion hold.

Parameters:
- RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = fixed priority, D over I.
- TIMEOUT, 255, maximum cycles spent in ACCESS waiting for m_ready (legal range 1..255).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out read.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- i_read_mem  in  1  I-cache read request.
- i_write_mem  in  1  I-cache write request.
- i_grant_mem  out  1  grant to I-cache.
- i_ready_mem  out  1  I-cache transaction complete.
- i_adbus  in  32  I-cache address, valid while i_grant_mem=1.
- i_wdata  in  32  I-cache write data.
- i_rdata  out  32  read data to I-cache.
- d_read_mem, d_write_mem, d_grant_mem, d_ready_mem, d_adbus, d_wdata, d_rdata: same as the I-cache set, for the D-cache.
- m_read  out  1  memory read strobe.
- m_write  out  1  memory write strobe.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, valid with m_ready.
- m_ready  in  1  memory access complete (1-cycle pulse or level).
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- All outputs are registered.
- Reset values: every grant/ready/m_* strobe = 0; m_addr, m_wdata, i_rdata, d_rdata = 0; busy = 0; timeout_err = 0; last_winner = I.
- Reset mid-transaction: all of the above return to reset values on the next edge, state = IDLE, and m_read/m_write drop immediately. The memory controller must tolerate an abandoned access.
- Per-port request: req = read_mem | write_mem. If both are high, write wins. The caches never do this; the bench checks the rule anyway.
- FSM states: IDLE -> GRANT -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any req, select the winner and go to GRANT; x_grant_mem = 1 from the next cycle.
  - Only one requester: it wins.
  - Both requesting, RR_EN=1: the port that is not last_winner wins.
  - Both requesting, RR_EN=0: D wins.
- GRANT (exactly 1 cycle):
  - The winner drives adbus/wdata during this cycle.
  - At the closing edge, latch m_addr, m_wdata and direction, assert m_read or m_write, clear the timeout counter, go to ACCESS.
  - If the winner's req has dropped by that edge (abort): grant = 0, return to IDLE, no memory access, last_winner unchanged.
- ACCESS:
  - m_read/m_write, m_addr and m_wdata are held stable; counter increments each cycle.
  - On m_ready: drop m_read/m_write; for reads latch m_rdata into the winner's x_rdata; x_ready_mem = 1; update last_winner; go to DONE.
  - If the counter reaches TIMEOUT with no m_ready: same as completion, but x_rdata = ERR_DATA and timeout_err is set.
  - m_ready arriving in the same cycle as the timeout: treated as a normal completion.
- DONE:
  - x_grant_mem, x_ready_mem and x_rdata are held until the winner's req is 0.
  - On that edge: grant = 0, ready = 0, go to IDLE.
  - A new request is evaluated one cycle later, giving a guaranteed 1-cycle idle gap between transactions.
- The loser's grant/ready stay 0 throughout; its request is held pending and not dropped.
- The non-granted port's x_rdata keeps its previous value.
- Latency, request to memory strobe: 2 cycles (req seen in IDLE -> GRANT -> strobe). Memory ready to x_ready_mem: 1 cycle.
- m_ready outside ACCESS is ignored.

Decomposition:
- Shared package mem_bus_pkg:
  - state encoding: IDLE=2'd0, GRANT=2'd1, ACCESS=2'd2, DONE=2'd3;
  - port id constants: PORT_I=1'b0, PORT_D=1'b1;
  - address/data width constant: 32.
- One natural sub-module, rr_arbiter2: combinational 2-way winner select from req_i, req_d, last_winner and RR_EN. The FSM, timeout counter and datapath registers stay in the top module.

Test Plan:
- I read only, addr 0x0000_0040, memory returns 0x1234_5678 after 3 cycles:
  - i_grant_mem 1 cycle after request; m_read with m_addr=0x40 at cycle +2;
  - i_ready_mem 1 cycle after m_ready with i_rdata=0x1234_5678, held until i_read_mem drops.
- D write to addr 0x100, data 0xCAFE_F00D:
  - m_write with m_addr=0x100, m_wdata=0xCAFE_F00D; d_ready_mem follows m_ready; I side stays quiet.
- I and D request in the same cycle, RR_EN=1, from reset:
  - D is served first (last_winner=I), then I after DONE plus 1 idle cycle.
  - Repeat: the order alternates.
  - With RR_EN=0, D always wins.
- Memory never asserts m_ready, TIMEOUT=8, D read:
  - d_ready_mem after 8 ACCESS cycles with d_rdata=0xDEAD_BEEF; timeout_err=1 and stays 1.
- Winner drops d_read_mem during GRANT:
  - no m_read pulse; return to IDLE; a pending I request is granted next.
- rst_n low for 1 cycle during ACCESS:
  - m_read, grants, ready, busy and timeout_err all 0 next edge; a fresh request after reset completes normally.
